// File: rtl/riscv_zero_pkg.sv
// Shared types and constants for the RISC-V Zero memory arbiter.
package riscv_zero_pkg;

    localparam int XLEN     = 32;
    localparam int STARVE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/riscv_zero_arb_pick.sv
// Priority policy: data wins unless fetch has been starved STARVE_MAX times.
module riscv_zero_arb_pick
    import riscv_zero_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                if_req_i,
    input  logic                d_req_i,
    input  logic [STARVE_W-1:0] starve_cnt_i,
    output arb_owner_t          winner_o,
    output logic                if_en_o,
    output logic                d_en_o
);

    logic d_wins;

    // Data wins while under the starvation limit, or whenever fetch is absent.
    always_comb begin
        d_wins = 1'b0;
        if (d_req_i && (starve_cnt_i < STARVE_W'(STARVE_MAX))) begin
            d_wins = 1'b1;
        end else if (d_req_i && !if_req_i) begin
            d_wins = 1'b1;
        end
        d_en_o   = d_wins;
        if_en_o  = if_req_i && !d_wins;
        winner_o = d_wins ? OWN_D : OWN_IF;
    end

endmodule

// File: rtl/riscv_zero_mem_arbiter.sv
// Shares one memory port between fetch and load/store; one transaction in flight.
// Handshake: a requester holds req with its payload until gnt is seen high in
// the same cycle; mem_req is held with a stable payload until mem_gnt, and the
// single response arrives later on mem_rvalid, routed to the latched owner.
module riscv_zero_mem_arbiter
    import riscv_zero_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req_i,
    input  logic [XLEN-1:0]     if_addr_i,
    input  logic                if_flush_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [XLEN-1:0]     if_rdata_o,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [3:0]          d_be_i,
    input  logic [XLEN-1:0]     d_addr_i,
    input  logic [XLEN-1:0]     d_wdata_i,
    output logic                d_gnt_o,
    output logic                d_rvalid_o,
    output logic [XLEN-1:0]     d_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [3:0]          mem_be_o,
    output logic [XLEN-1:0]     mem_addr_o,
    output logic [XLEN-1:0]     mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [XLEN-1:0]     mem_rdata_i,
    output arb_state_t          state_o,
    output logic [STARVE_W-1:0] starve_cnt_o
);

    arb_state_t          state_q, state_d;
    arb_owner_t          owner_q, owner_d;
    logic                drop_q, drop_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic                we_q, we_d;
    logic [3:0]          be_q, be_d;

    arb_owner_t pick_winner;
    logic       pick_if_en;
    logic       pick_d_en;

    riscv_zero_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .if_req_i     (if_req_i),
        .d_req_i      (d_req_i),
        .starve_cnt_i (starve_q),
        .winner_o     (pick_winner),
        .if_en_o      (pick_if_en),
        .d_en_o       (pick_d_en)
    );

    // State register and latched request payload; reset abandons any transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= OWN_IF;
            drop_q   <= 1'b0;
            starve_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            drop_q   <= drop_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            be_q     <= be_d;
        end
    end

    // Next-state, grant, starvation and response-routing logic.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        drop_d      = drop_q;
        starve_d    = starve_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        be_d        = be_q;
        if_gnt_o    = 1'b0;
        d_gnt_o     = 1'b0;
        if_rvalid_o = 1'b0;
        d_rvalid_o  = 1'b0;
        mem_req_o   = 1'b0;
        case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                // Grants are combinational, so hold them off while reset is high.
                if (!reset && (pick_if_en || pick_d_en)) begin
                    if_gnt_o = pick_if_en;
                    d_gnt_o  = pick_d_en;
                    owner_d  = pick_winner;
                    state_d  = REQ;
                    if (pick_d_en) begin
                        addr_d  = d_addr_i;
                        wdata_d = d_wdata_i;
                        we_d    = d_we_i;
                        be_d    = d_be_i;
                        if (if_req_i && (starve_q < STARVE_W'(STARVE_MAX))) begin
                            starve_d = starve_q + STARVE_W'(1);
                        end
                    end else begin
                        addr_d   = if_addr_i;
                        wdata_d  = '0;
                        we_d     = 1'b0;
                        be_d     = 4'hF;
                        starve_d = '0;
                    end
                end
            end
            REQ: begin
                mem_req_o = 1'b1;
                if (owner_q == OWN_IF && if_flush_i) begin
                    drop_d = 1'b1;
                end
                if (mem_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (owner_q == OWN_IF && if_flush_i) begin
                    drop_d = 1'b1;
                end
                if (mem_rvalid_i) begin
                    if (owner_q == OWN_D) begin
                        d_rvalid_o = 1'b1;
                    end else begin
                        // A flush in the response cycle itself also kills the data.
                        if_rvalid_o = !(drop_q || if_flush_i);
                    end
                    state_d = IDLE;
                    drop_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_we_o     = we_q;
    assign mem_be_o     = be_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign if_rdata_o   = mem_rdata_i;
    assign d_rdata_o    = mem_rdata_i;
    assign state_o      = state_q;
    assign starve_cnt_o = starve_q;

endmodule
